// File: rtl/ysyx_041514_mem_access.sv
// rtl/ysyx_041514_mem_access.sv - MEM stage load/store unit on a single-outstanding dmem req/rsp bus
// Optional: YSYX_041514_MISALIGN_TRAP_EN flags misaligned accesses instead of aligning them down.
module ysyx_041514_mem_access #(
    parameter int XLEN      = 64,
    parameter int MEMOP_LEN = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush_i,
    input  logic                 stall_i,
    input  logic [MEMOP_LEN-1:0] mem_op_i,
    input  logic [XLEN-1:0]      alu_data_i,
    input  logic [XLEN-1:0]      rs2_data_i,
    output logic                 dmem_req_valid_o,
    input  logic                 dmem_req_ready_i,
    output logic [XLEN-1:0]      dmem_req_addr_o,
    output logic                 dmem_req_wen_o,
    output logic [1:0]           dmem_req_size_o,
    output logic [63:0]          dmem_req_wdata_o,
    output logic [7:0]           dmem_req_wstrb_o,
    input  logic                 dmem_rsp_valid_i,
    input  logic [63:0]          dmem_rsp_rdata_i,
    output logic [XLEN-1:0]      result_o,
    output logic                 stall_req_o,
    output logic                 misalign_o
);

    localparam logic [MEMOP_LEN-1:0] OP_LB  = MEMOP_LEN'(1);
    localparam logic [MEMOP_LEN-1:0] OP_LH  = MEMOP_LEN'(2);
    localparam logic [MEMOP_LEN-1:0] OP_LW  = MEMOP_LEN'(3);
    localparam logic [MEMOP_LEN-1:0] OP_LD  = MEMOP_LEN'(4);
    localparam logic [MEMOP_LEN-1:0] OP_LBU = MEMOP_LEN'(5);
    localparam logic [MEMOP_LEN-1:0] OP_LHU = MEMOP_LEN'(6);
    localparam logic [MEMOP_LEN-1:0] OP_LWU = MEMOP_LEN'(7);
    localparam logic [MEMOP_LEN-1:0] OP_SB  = MEMOP_LEN'(8);
    localparam logic [MEMOP_LEN-1:0] OP_SH  = MEMOP_LEN'(9);
    localparam logic [MEMOP_LEN-1:0] OP_SW  = MEMOP_LEN'(10);
    localparam logic [MEMOP_LEN-1:0] OP_SD  = MEMOP_LEN'(11);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [XLEN-1:0]        addr_q;
    logic [1:0]             size_q;
    logic                   wen_q;
    logic [63:0]            wdata_q;
    logic [7:0]             wstrb_q;
    logic [MEMOP_LEN-1:0]   op_q;
    logic                   kill_q, kill_d;
    logic [XLEN-1:0]        buf_q;

    logic                   dec_mem;
    logic                   dec_store;
    logic [1:0]             dec_size;
    logic [2:0]             size_mask;
    logic [XLEN-1:0]        req_addr_d;
    logic [63:0]            wdata_d;
    logic [7:0]             wstrb_d;
    logic [63:0]            lane_word;
    logic [XLEN-1:0]        load_data;
    logic                   latch;
    logic                   capture;
    logic                   stall_req;
    logic                   misalign;

    always_comb begin
        dec_mem   = 1'b1;
        dec_store = 1'b0;
        dec_size  = 2'd0;
        case (mem_op_i)
            OP_LB, OP_LBU: dec_size = 2'd0;
            OP_LH, OP_LHU: dec_size = 2'd1;
            OP_LW, OP_LWU: dec_size = 2'd2;
            OP_LD:         dec_size = 2'd3;
            OP_SB: begin dec_store = 1'b1; dec_size = 2'd0; end
            OP_SH: begin dec_store = 1'b1; dec_size = 2'd1; end
            OP_SW: begin dec_store = 1'b1; dec_size = 2'd2; end
            OP_SD: begin dec_store = 1'b1; dec_size = 2'd3; end
            default: dec_mem = 1'b0;
        endcase
    end

    always_comb begin
        size_mask = 3'b000;
        wdata_d   = rs2_data_i[63:0];
        case (dec_size)
            2'd0: begin size_mask = 3'b000; wdata_d = {8{rs2_data_i[7:0]}};  end
            2'd1: begin size_mask = 3'b001; wdata_d = {4{rs2_data_i[15:0]}}; end
            2'd2: begin size_mask = 3'b011; wdata_d = {2{rs2_data_i[31:0]}}; end
            default: begin size_mask = 3'b111; wdata_d = rs2_data_i[63:0]; end
        endcase
    end

    // Low address bits are cleared to the access size; a no-op for aligned addresses.
    assign req_addr_d = {alu_data_i[XLEN-1:3], alu_data_i[2:0] & ~size_mask};

    always_comb begin
        wstrb_d = 8'h00;
        if (dec_store) begin
            case (dec_size)
                2'd0:    wstrb_d = 8'h01 << req_addr_d[2:0];
                2'd1:    wstrb_d = 8'h03 << req_addr_d[2:0];
                2'd2:    wstrb_d = 8'h0F << req_addr_d[2:0];
                default: wstrb_d = 8'hFF;
            endcase
        end
    end

    assign lane_word = dmem_rsp_rdata_i >> {addr_q[2:0], 3'b000};

    always_comb begin
        load_data = lane_word;
        case (op_q)
            OP_LB:   load_data = {{56{lane_word[7]}},  lane_word[7:0]};
            OP_LH:   load_data = {{48{lane_word[15]}}, lane_word[15:0]};
            OP_LW:   load_data = {{32{lane_word[31]}}, lane_word[31:0]};
            OP_LBU:  load_data = {56'd0, lane_word[7:0]};
            OP_LHU:  load_data = {48'd0, lane_word[15:0]};
            OP_LWU:  load_data = {32'd0, lane_word[31:0]};
            default: load_data = lane_word;
        endcase
    end

`ifdef YSYX_041514_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned = |(alu_data_i[2:0] & size_mask);
`endif

    always_comb begin
        state_d   = state_q;
        kill_d    = kill_q;
        latch     = 1'b0;
        capture   = 1'b0;
        stall_req = 1'b0;
        misalign  = 1'b0;
        result_o  = buf_q;
        case (state_q)
            S_IDLE: begin
                result_o = alu_data_i;
                if (dec_mem && !flush_i) begin
`ifdef YSYX_041514_MISALIGN_TRAP_EN
                    if (misaligned) begin
                        misalign = 1'b1;
                    end else begin
                        latch     = 1'b1;
                        stall_req = 1'b1;
                        state_d   = S_REQ;
                    end
`else
                    latch     = 1'b1;
                    stall_req = 1'b1;
                    state_d   = S_REQ;
`endif
                end
            end
            S_REQ: begin
                stall_req = 1'b1;
                // An accepted request always produces a response, so a flush racing the
                // handshake still has to drain it through WAIT.
                if (dmem_req_ready_i) begin
                    state_d = S_WAIT;
                    if (flush_i) kill_d = 1'b1;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                stall_req = 1'b1;
                if (flush_i) kill_d = 1'b1;
                if (dmem_rsp_valid_i) begin
                    if (kill_q || flush_i) begin
                        kill_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        capture = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (!stall_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            size_q  <= 2'd0;
            wen_q   <= 1'b0;
            wdata_q <= 64'd0;
            wstrb_q <= 8'h00;
            op_q    <= '0;
            kill_q  <= 1'b0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            kill_q  <= kill_d;
            if (latch) begin
                addr_q  <= req_addr_d;
                size_q  <= dec_size;
                wen_q   <= dec_store;
                wdata_q <= wdata_d;
                wstrb_q <= wstrb_d;
                op_q    <= mem_op_i;
            end
            if (capture) buf_q <= wen_q ? '0 : load_data;
        end
    end

    // Combinational outputs are masked while reset is held so nothing leaks onto the bus.
    assign dmem_req_valid_o = rst && (state_q == S_REQ);
    assign dmem_req_addr_o  = addr_q;
    assign dmem_req_wen_o   = wen_q;
    assign dmem_req_size_o  = size_q;
    assign dmem_req_wdata_o = wdata_q;
    assign dmem_req_wstrb_o = wstrb_q;
    assign stall_req_o      = rst && stall_req;
    assign misalign_o       = rst && misalign;

endmodule

// File: tb/tb_ysyx_041514_mem_access.sv
// tb/tb_ysyx_041514_mem_access.sv - directed scoreboard bench for the MEM stage load/store unit
module tb_ysyx_041514_mem_access;

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LH   = 4'd2;
    localparam logic [3:0] OP_LW   = 4'd3;
    localparam logic [3:0] OP_LD   = 4'd4;
    localparam logic [3:0] OP_LBU  = 4'd5;
    localparam logic [3:0] OP_LWU  = 4'd7;
    localparam logic [3:0] OP_SB   = 4'd8;
    localparam logic [3:0] OP_SH   = 4'd9;
    localparam logic [3:0] OP_SW   = 4'd10;
    localparam logic [3:0] OP_SD   = 4'd11;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        stall_i;
    logic [3:0]  mem_op_i;
    logic [63:0] alu_data_i;
    logic [63:0] rs2_data_i;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic [63:0] dmem_req_addr_o;
    logic        dmem_req_wen_o;
    logic [1:0]  dmem_req_size_o;
    logic [63:0] dmem_req_wdata_o;
    logic [7:0]  dmem_req_wstrb_o;
    logic        dmem_rsp_valid_i;
    logic [63:0] dmem_rsp_rdata_i;
    logic [63:0] result_o;
    logic        stall_req_o;
    logic        misalign_o;

    ysyx_041514_mem_access dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .stall_i          (stall_i),
        .mem_op_i         (mem_op_i),
        .alu_data_i       (alu_data_i),
        .rs2_data_i       (rs2_data_i),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_req_addr_o  (dmem_req_addr_o),
        .dmem_req_wen_o   (dmem_req_wen_o),
        .dmem_req_size_o  (dmem_req_size_o),
        .dmem_req_wdata_o (dmem_req_wdata_o),
        .dmem_req_wstrb_o (dmem_req_wstrb_o),
        .dmem_rsp_valid_i (dmem_rsp_valid_i),
        .dmem_rsp_rdata_i (dmem_rsp_rdata_i),
        .result_o         (result_o),
        .stall_req_o      (stall_req_o),
        .misalign_o       (misalign_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [1:0]  size;
        logic        wen;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
    } req_t;

    req_t        exp_req[$];
    logic [63:0] exp_res[$];
    int          n_assert = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkb(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [63:0] addr, input logic [1:0] size, input logic wen,
                            input logic [63:0] wdata, input logic [7:0] wstrb, input logic [63:0] res);
        req_t r;
        r.addr  = addr;
        r.size  = size;
        r.wen   = wen;
        r.wdata = wdata;
        r.wstrb = wstrb;
        exp_req.push_back(r);
        exp_res.push_back(res);
    endtask

    task automatic access(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] rs2,
                          input int ready_delay, input logic [63:0] rdata, input int hold);
        req_t        er;
        logic [63:0] eres;
        logic [63:0] idle_alu;
        bit          hs;
        @(negedge clk);
        mem_op_i = op; alu_data_i = addr; rs2_data_i = rs2;
        dmem_req_ready_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
        #1;
        chkb("op_stall", stall_req_o, 1'b1);
        chkb("op_no_valid", dmem_req_valid_o, 1'b0);
        chkb("op_no_misalign", misalign_o, 1'b0);
        er = exp_req.pop_front();
        hs = 1'b0;
        for (int c = 0; c < 20 && !hs; c++) begin
            @(negedge clk);
            mem_op_i = OP_NONE; alu_data_i = {$urandom(), $urandom()}; rs2_data_i = {$urandom(), $urandom()};
            dmem_req_ready_i = (c >= ready_delay);
            #1;
            chkb("req_valid", dmem_req_valid_o, 1'b1);
            chkb("req_stall", stall_req_o, 1'b1);
            chk("req_addr", dmem_req_addr_o, er.addr);
            chk("req_size", 64'(dmem_req_size_o), 64'(er.size));
            chkb("req_wen", dmem_req_wen_o, er.wen);
            chk("req_wstrb", 64'(dmem_req_wstrb_o), 64'(er.wstrb));
            if (er.wen) chk("req_wdata", dmem_req_wdata_o, er.wdata);
            hs = dmem_req_ready_i;
        end
        if (!hs) chkb("handshake_timeout", 1'b0, 1'b1);
        @(negedge clk);
        dmem_req_ready_i = 1'b0; dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = rdata;
        #1;
        chkb("wait_stall", stall_req_o, 1'b1);
        chkb("wait_single_req", dmem_req_valid_o, 1'b0);
        eres = exp_res.pop_front();
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            dmem_rsp_valid_i = 1'b0; dmem_rsp_rdata_i = {$urandom(), $urandom()};
            stall_i = (h < hold);
            #1;
            chk("done_result", result_o, eres);
            chkb("done_stall", stall_req_o, 1'b0);
        end
        idle_alu = {$urandom(), $urandom()};
        @(negedge clk);
        stall_i = 1'b0; alu_data_i = idle_alu; dmem_rsp_valid_i = 1'b1;
        #1;
        chk("idle_result", result_o, idle_alu);
        chkb("idle_stall", stall_req_o, 1'b0);
        @(negedge clk);
        dmem_rsp_valid_i = 1'b0;
        #1;
        chk("stray_rsp_ignored", result_o, idle_alu);
        chkb("stray_rsp_no_valid", dmem_req_valid_o, 1'b0);
        chkb("stray_rsp_no_stall", stall_req_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        rst = 1'b0; flush_i = 1'b0; stall_i = 1'b0; mem_op_i = OP_NONE;
        alu_data_i = 64'd0; rs2_data_i = 64'd0; dmem_req_ready_i = 1'b0;
        dmem_rsp_valid_i = 1'b0; dmem_rsp_rdata_i = 64'd0;

        // Reset held with random inputs
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            mem_op_i = 4'($urandom_range(0, 15)); alu_data_i = {$urandom(), $urandom()};
            rs2_data_i = {$urandom(), $urandom()}; flush_i = 1'($urandom_range(0, 1));
            dmem_req_ready_i = 1'($urandom_range(0, 1)); dmem_rsp_valid_i = 1'($urandom_range(0, 1));
            #1;
            chkb("rst_valid", dmem_req_valid_o, 1'b0);
            chkb("rst_stall", stall_req_o, 1'b0);
            chkb("rst_misalign", misalign_o, 1'b0);
            if (i > 0) begin
                chk("rst_wstrb", 64'(dmem_req_wstrb_o), 64'd0);
                chkb("rst_wen", dmem_req_wen_o, 1'b0);
            end
        end
        @(negedge clk);
        rst = 1'b1; flush_i = 1'b0; mem_op_i = OP_NONE; alu_data_i = 64'h1234;
        dmem_req_ready_i = 1'b0; dmem_rsp_valid_i = 1'b0;
        #1;
        chk("passthru_result", result_o, 64'h1234);
        chkb("passthru_stall", stall_req_o, 1'b0);

        // Loads with sign/zero extension, stores with lane replication
        exp_push(64'h8000_0003, 2'd0, 1'b0, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80);
        access(OP_LB, 64'h8000_0003, 64'd0, 0, 64'h0000_0000_8000_0000, 0);
        exp_push(64'h8000_0003, 2'd0, 1'b0, 64'd0, 8'h00, 64'h0000_0000_0000_0080);
        access(OP_LBU, 64'h8000_0003, 64'd0, 0, 64'h0000_0000_8000_0000, 0);
        exp_push(64'h8000_0006, 2'd1, 1'b1, 64'hABCD_ABCD_ABCD_ABCD, 8'hC0, 64'd0);
        access(OP_SH, 64'h8000_0006, 64'h1111_2222_3333_ABCD, 3, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        exp_push(64'h8000_000A, 2'd1, 1'b0, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_F00D);
        access(OP_LH, 64'h8000_000A, 64'd0, 1, 64'h0000_0000_F00D_0000, 0);
        exp_push(64'h8000_0004, 2'd2, 1'b0, 64'd0, 8'h00, 64'h0000_0000_8765_4321);
        access(OP_LWU, 64'h8000_0004, 64'd0, 0, 64'h8765_4321_0000_0000, 0);
        exp_push(64'h8000_0004, 2'd2, 1'b1, 64'h1122_3344_1122_3344, 8'hF0, 64'd0);
        access(OP_SW, 64'h8000_0004, 64'h0000_0000_1122_3344, 0, 64'd0, 0);
        exp_push(64'h8000_0005, 2'd0, 1'b1, 64'hA5A5_A5A5_A5A5_A5A5, 8'h20, 64'd0);
        access(OP_SB, 64'h8000_0005, 64'h0000_0000_0000_00A5, 0, 64'd0, 0);
        exp_push(64'h8000_0008, 2'd3, 1'b1, 64'h0102_0304_0506_0708, 8'hFF, 64'd0);
        access(OP_SD, 64'h8000_0008, 64'h0102_0304_0506_0708, 1, 64'd0, 0);
        exp_push(64'h8000_0010, 2'd3, 1'b0, 64'd0, 8'h00, 64'h0123_4567_89AB_CDEF);
        access(OP_LD, 64'h8000_0010, 64'd0, 0, 64'h0123_4567_89AB_CDEF, 4);

        // Misaligned word load
`ifdef YSYX_041514_MISALIGN_TRAP_EN
        @(negedge clk);
        mem_op_i = OP_LW; alu_data_i = 64'h8000_0002;
        #1;
        chkb("trap_misalign", misalign_o, 1'b1);
        chkb("trap_no_valid", dmem_req_valid_o, 1'b0);
        chkb("trap_stall", stall_req_o, 1'b0);
        chk("trap_result", result_o, 64'h8000_0002);
        @(negedge clk);
        mem_op_i = OP_NONE;
        #1;
        chkb("trap_no_req", dmem_req_valid_o, 1'b0);
        chkb("trap_clear", misalign_o, 1'b0);
`else
        exp_push(64'h8000_0000, 2'd2, 1'b0, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFE);
        access(OP_LW, 64'h8000_0002, 64'd0, 0, 64'h0000_0000_FFFF_FFFE, 0);
`endif

        // Flush of a mem op while still in IDLE
        @(negedge clk);
        mem_op_i = OP_LD; alu_data_i = 64'h40; flush_i = 1'b1;
        #1;
        chkb("flush_idle_stall", stall_req_o, 1'b0);
        @(negedge clk);
        mem_op_i = OP_NONE; flush_i = 1'b0;
        #1;
        chkb("flush_idle_no_req", dmem_req_valid_o, 1'b0);

        // Flush while the request is pending
        @(negedge clk);
        mem_op_i = OP_SD; alu_data_i = 64'h100; rs2_data_i = 64'h5A5A;
        #1;
        chkb("flush_req_stall0", stall_req_o, 1'b1);
        @(negedge clk);
        mem_op_i = OP_NONE; flush_i = 1'b1;
        #1;
        chkb("flush_req_valid", dmem_req_valid_o, 1'b1);
        @(negedge clk);
        flush_i = 1'b0; dmem_req_ready_i = 1'b1; alu_data_i = 64'h99;
        #1;
        chkb("flush_req_dropped", dmem_req_valid_o, 1'b0);
        chkb("flush_req_unstall", stall_req_o, 1'b0);
        chk("flush_req_result", result_o, 64'h99);

        // Flush while waiting for the response
        @(negedge clk);
        dmem_req_ready_i = 1'b0; mem_op_i = OP_LD; alu_data_i = 64'h200;
        #1;
        chkb("flush_wait_stall0", stall_req_o, 1'b1);
        @(negedge clk);
        mem_op_i = OP_NONE; dmem_req_ready_i = 1'b1;
        #1;
        chkb("flush_wait_req", dmem_req_valid_o, 1'b1);
        @(negedge clk);
        dmem_req_ready_i = 1'b0; flush_i = 1'b1;
        #1;
        chkb("flush_wait_stall", stall_req_o, 1'b1);
        chkb("flush_wait_novalid", dmem_req_valid_o, 1'b0);
        @(negedge clk);
        flush_i = 1'b0; dmem_rsp_valid_i = 1'b1; dmem_rsp_rdata_i = 64'hDEAD;
        #1;
        chkb("flush_wait_still", stall_req_o, 1'b1);
        @(negedge clk);
        dmem_rsp_valid_i = 1'b0; alu_data_i = 64'h77;
        #1;
        chk("flush_wait_discard", result_o, 64'h77);
        chkb("flush_wait_idle", stall_req_o, 1'b0);

        // Reset in the middle of a request
        @(negedge clk);
        mem_op_i = OP_SD; alu_data_i = 64'h300; rs2_data_i = 64'h1;
        #1;
        chkb("midrst_stall0", stall_req_o, 1'b1);
        @(negedge clk);
        mem_op_i = OP_NONE;
        #1;
        chkb("midrst_req", dmem_req_valid_o, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chkb("midrst_valid_masked", dmem_req_valid_o, 1'b0);
        chkb("midrst_stall_masked", stall_req_o, 1'b0);
        @(negedge clk);
        rst = 1'b1; dmem_req_ready_i = 1'b1;
        #1;
        chkb("midrst_no_req", dmem_req_valid_o, 1'b0);
        chkb("midrst_no_stall", stall_req_o, 1'b0);
        @(negedge clk);
        dmem_req_ready_i = 1'b0; dmem_rsp_valid_i = 1'b1; alu_data_i = 64'h42;
        #1;
        chk("midrst_late_rsp", result_o, 64'h42);
        @(negedge clk);
        dmem_rsp_valid_i = 1'b0;
        #1;
        chkb("midrst_late_rsp_stall", stall_req_o, 1'b0);
        chk("midrst_late_rsp_result", result_o, 64'h42);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
